mul_div_seq: RTL

Sequential 8-bit unsigned multiplier/divider controller built around one shared `SumatorScazator` instance, an 8-bit add/subtract unit with carry-out. The controller iterates shift-and-add for multiply and restoring subtraction for divide, one adder operation per clock. It produces a 16-bit result under a start/busy/done handshake. It sits between the operand registers and the result bus of the FC arithmetic unit, and is the only user of its adder instance.

---
 rtl/mul_div_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/mul_div_seq.sv
// mul_div_seq: sequential 8-bit shift-add multiplier / restoring divider sharing one adder.
// Divide datapath is compiled in only when MUL_DIV_SEQ_DIV_EN is defined.
module SumatorScazator (
  input  logic [7:0] in_1,
  input  logic [7:0] in_2,
  input  logic       sub,
  output logic [7:0] s,
  output logic       cout
);
  assign {cout, s} = sub ? {1'b0, in_1} + {1'b0, ~in_2} + 9'd1 : {1'b0, in_1} + {1'b0, in_2};
endmodule

module mul_div_seq #(
  parameter logic [15:0] ZERO_DIV_RESULT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [7:0]  in_1,
  input  logic [7:0]  in_2,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic [7:0] a, h, l, add_a, add_b, sum;
  logic [15:0] p_nx, res_nx;
  logic sub, cout, rej, reject;
`ifdef MUL_DIV_SEQ_DIV_EN
  logic [7:0] b, r, q, t, r_nx, q_nx;
  logic op_r, ok;
  assign reject = op && in_2 == 8'd0;
  assign t = {r[6:0], q[7]};
  assign ok = r[7] | cout;
  assign r_nx = ok ? sum : t;
  assign q_nx = {q[6:0], ok};
  assign sub = op_r;
  assign add_a = op_r ? t : h;
  assign add_b = op_r ? b : a;
  assign res_nx = op_r ? {r_nx, q_nx} : p_nx;
`else
  assign reject = op;
  assign sub = 1'b0;
  assign add_a = h;
  assign add_b = a;
  assign res_nx = p_nx;
`endif
  assign p_nx = l[0] ? {cout, sum, l[7:1]} : {1'b0, h, l[7:1]};
  assign busy = state != IDLE;
  assign done = state == DONE;
  SumatorScazator adder (.in_1(add_a), .in_2(add_b), .sub(sub), .s(sum), .cout(cout));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // A rejected op spends one RUN cycle without iterating so done lands one edge after accept.
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE)
             : state == RUN  ? ((rej || cnt == 3'd7) ? DONE : RUN)
             : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      a <= '0;
      h <= '0;
      l <= '0;
      rej <= 1'b0;
      result <= '0;
      err <= 1'b0;
`ifdef MUL_DIV_SEQ_DIV_EN
      b <= '0;
      op_r <= 1'b0;
      r <= '0;
      q <= '0;
`endif
    end else if (state == IDLE && start) begin
      cnt <= '0;
      a <= in_1;
      h <= '0;
      l <= in_2;
      rej <= reject;
`ifdef MUL_DIV_SEQ_DIV_EN
      b <= in_2;
      op_r <= op;
      r <= '0;
      q <= in_1;
`endif
    end else if (state == RUN && rej) begin
      result <= ZERO_DIV_RESULT;
      err <= 1'b1;
    end else if (state == RUN) begin
      cnt <= cnt + 3'd1;
      {h, l} <= p_nx;
`ifdef MUL_DIV_SEQ_DIV_EN
      r <= r_nx;
      q <= q_nx;
`endif
      if (cnt == 3'd7) begin
        result <= res_nx;
        err <= 1'b0;
      end
    end
endmodule
